// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositing layer.
package sprite_pkg;

    localparam int SPR_COORD_W             = 10;
    localparam int TRANSPARENT_IDX_DEFAULT = 0;

    typedef struct packed {
        logic [SPR_COORD_W-1:0] x;
        logic [SPR_COORD_W-1:0] y;
        logic                   en;
        logic                   flip;
        logic                   anim_en;
    } sprite_attr_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: stage-1 hit test and ROM address generation, plus its animation counter.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 50,
    parameter int SPR_H      = 50,
    parameter int NUM_FRAMES = 4,
    parameter int ANIM_DIV   = 8,
    parameter int ADDR_W     = 14
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    input  logic [SPR_COORD_W-1:0] draw_x,
    input  logic [SPR_COORD_W-1:0] draw_y,
    input  logic                   frame_tick,
    input  sprite_attr_t           attr,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic                   hit_q
);

    localparam int FRM_W  = clog2_min1(NUM_FRAMES);
    localparam int DIV_W  = clog2_min1(ANIM_DIV);
    // Two extra bits keep the offset from the sprite's top-left corner signed and overflow-free.
    localparam int CALC_W = SPR_COORD_W + 2;

    logic [DIV_W-1:0]  div_cnt;
    logic [FRM_W-1:0]  frame;
    logic [CALC_W-1:0] col;
    logic [CALC_W-1:0] row;
    logic [CALC_W-1:0] col_fx;
    logic              hit;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        col    = CALC_W'(draw_x) - CALC_W'(attr.x) + CALC_W'(SPR_W / 2);
        row    = CALC_W'(draw_y) - CALC_W'(attr.y) + CALC_W'(SPR_H / 2);
        hit    = attr.en && !col[CALC_W-1] && (col < CALC_W'(SPR_W))
                         && !row[CALC_W-1] && (row < CALC_W'(SPR_H));
        col_fx = attr.flip ? (CALC_W'(SPR_W - 1) - col) : col;
        addr   = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
               + ADDR_W'(row) * ADDR_W'(SPR_W)
               + ADDR_W'(col_fx);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_addr <= '0;
            hit_q    <= 1'b0;
        end else begin
            rom_addr <= hit ? addr : '0;
            hit_q    <= hit;
        end
    end

    // Disabling animation snaps straight back to frame 0, even if a tick arrives in the same cycle.
    always_ff @(posedge vga_clk) begin
        if (reset || !attr.anim_en) begin
            div_cnt <= '0;
            frame   <= '0;
        end else if (frame_tick) begin
            if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt <= '0;
                frame   <= (frame == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Composites NUM_SPRITES sprite channels into one palette-index pixel stream, 3-cycle latency.
module sprite_layer_renderer
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES     = 4,
    parameter int SPR_W           = 50,
    parameter int SPR_H           = 50,
    parameter int NUM_FRAMES      = 4,
    parameter int IDX_W           = 3,
    parameter int ANIM_DIV        = 8,
    parameter int TRANSPARENT_IDX = TRANSPARENT_IDX_DEFAULT,
    localparam int ADDR_W         = $clog2(SPR_W * SPR_H * NUM_FRAMES),
    localparam int SID_W          = clog2_min1(NUM_SPRITES)
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic [9:0]                    draw_x,
    input  logic [9:0]                    draw_y,
    input  logic                          blank,
    input  logic                          frame_tick,
    input  logic [NUM_SPRITES*10-1:0]     spr_x,
    input  logic [NUM_SPRITES*10-1:0]     spr_y,
    input  logic [NUM_SPRITES-1:0]        spr_en,
    input  logic [NUM_SPRITES-1:0]        spr_flip,
    input  logic [NUM_SPRITES-1:0]        spr_anim_en,
    output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPRITES*IDX_W-1:0]  rom_q,
    output logic                          pix_valid,
    output logic [IDX_W-1:0]              pix_idx,
    output logic [SID_W-1:0]              pix_sprite
);

    logic [NUM_SPRITES-1:0] hit_d1;
    logic [NUM_SPRITES-1:0] hit_d2;
    logic                   blank_d1;
    logic                   blank_d2;
    logic                   win_valid;
    logic [IDX_W-1:0]       win_idx;
    logic [SID_W-1:0]       win_sel;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_chan
        sprite_attr_t attr;

        assign attr = {spr_x[10*i +: 10], spr_y[10*i +: 10], spr_en[i], spr_flip[i], spr_anim_en[i]};

        sprite_channel #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .NUM_FRAMES (NUM_FRAMES),
            .ANIM_DIV   (ANIM_DIV),
            .ADDR_W     (ADDR_W)
        ) u_chan (
            .vga_clk    (vga_clk),
            .reset      (reset),
            .draw_x     (draw_x),
            .draw_y     (draw_y),
            .frame_tick (frame_tick),
            .attr       (attr),
            .rom_addr   (rom_addr[ADDR_W*i +: ADDR_W]),
            .hit_q      (hit_d1[i])
        );
    end

    // Hit and blank ride alongside the ROM read so they line up with rom_q.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blank_d1 <= 1'b0;
            blank_d2 <= 1'b0;
            hit_d2   <= '0;
        end else begin
            blank_d1 <= blank;
            blank_d2 <= blank_d1;
            hit_d2   <= hit_d1;
        end
    end

    // Scanning from the highest channel down lets the lowest opaque channel win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_sel   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_d2[i] && blank_d2 && (rom_q[IDX_W*i +: IDX_W] != IDX_W'(TRANSPARENT_IDX))) begin
                win_valid = 1'b1;
                win_idx   = rom_q[IDX_W*i +: IDX_W];
                win_sel   = SID_W'(i);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pix_valid  <= 1'b0;
            pix_idx    <= '0;
            pix_sprite <= '0;
        end else begin
            pix_valid  <= win_valid;
            pix_idx    <= win_idx;
            pix_sprite <= win_sel;
        end
    end

endmodule
